// File: rtl/aes_ctrl_pkg.sv
// Shared constants and FSM state encoding for the AES request arbiter.
// Consumed by aes_req_arbiter and aes_rr_arbiter.
package aes_ctrl_pkg;

  localparam int NUM_REQ                = 2;
  localparam int AES_BLOCK_W            = 128;
  localparam int TIMEOUT_W              = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin pick: the sole eligible requester wins, and on a tie
// the requester that was not served last wins. Purely combinational.
module aes_rr_arbiter
  import aes_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               last_grant,
  output logic               gnt_valid,
  output logic               gnt_id
);

  always_comb begin
    gnt_valid = |eligible;
    if (eligible == 2'b11) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = eligible[1];
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one aes_encipher core between two requesters with round-robin grant.
// Optional abort on a stuck core is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [AES_BLOCK_W-1:0] req0_key,
  input  logic [AES_BLOCK_W-1:0] req0_data,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [AES_BLOCK_W-1:0] rsp0_data,
  output logic                   rsp0_err,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [AES_BLOCK_W-1:0] req1_key,
  input  logic [AES_BLOCK_W-1:0] req1_data,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [AES_BLOCK_W-1:0] rsp1_data,
  output logic                   rsp1_err,
  output logic                   core_init,
  output logic [AES_BLOCK_W-1:0] core_key,
  output logic [AES_BLOCK_W-1:0] core_plaintext,
  input  logic [AES_BLOCK_W-1:0] core_ciphertext,
  input  logic                   core_ready,
  output logic                   busy,
  output logic                   grant_id
);

  arb_state_e             state, next_state;
  logic [AES_BLOCK_W-1:0] key_reg, pt_reg;
  logic                   last_grant, grant_q;
  logic [NUM_REQ-1:0]     eligible, rsp_valid_q, rsp_ready_v;
  logic [AES_BLOCK_W-1:0] rsp_data_q [NUM_REQ];
  logic                   gnt_valid, gnt_id;
  logic                   accept, done_ok, abort;

  // A requester with an unconsumed result is not eligible again.
  assign eligible    = {req1_valid & ~rsp_valid_q[1], req0_valid & ~rsp_valid_q[0]};
  assign rsp_ready_v = {rsp1_ready, rsp0_ready};

  aes_rr_arbiter u_rr (
    .eligible   (eligible),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign accept     = (state == IDLE) & gnt_valid;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;
  assign done_ok    = (state == WAIT_DONE) & core_ready;

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [NUM_REQ-1:0]   rsp_err_q;
  logic                 waiting, tmo_hit;

  assign waiting = (state == WAIT_BUSY) | (state == WAIT_DONE);
  assign tmo_hit = waiting & (tmo_cnt == TMO_LIMIT);
  assign abort   = tmo_hit & ~done_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if (waiting && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((done_ok || abort) && grant_q == 1'(i)) begin
          rsp_err_q[i] <= abort;
        end
      end
    end
  end

  assign rsp0_err = rsp_err_q[0];
  assign rsp1_err = rsp_err_q[1];
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign rsp0_err       = 1'b0;
  assign rsp1_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      key_reg    <= '0;
      pt_reg     <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        last_grant <= gnt_id;
        grant_q    <= gnt_id;
        key_reg    <= gnt_id ? req1_key  : req0_key;
        pt_reg     <= gnt_id ? req1_data : req0_data;
      end
    end
  end

  // The core idles with ready high, so completion only counts after it has dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (gnt_valid) next_state = ISSUE;
      ISSUE:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (abort) begin
          next_state = GAP;
        end else if (!core_ready) begin
          next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: if (done_ok || abort) next_state = GAP;
      GAP:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid_q[i] && rsp_ready_v[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
        if ((done_ok || abort) && grant_q == 1'(i)) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= done_ok ? core_ciphertext : '0;
        end
      end
    end
  end

  assign rsp0_valid     = rsp_valid_q[0];
  assign rsp1_valid     = rsp_valid_q[1];
  assign rsp0_data      = rsp_data_q[0];
  assign rsp1_data      = rsp_data_q[1];
  assign core_init      = (state == ISSUE);
  assign core_key       = key_reg;
  assign core_plaintext = pt_reg;
  assign busy           = (state != IDLE);
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter with a behavioural AES core stand-in
// and a cycle-level transaction model of grant, latency and response rules.
module tb_aes_req_arbiter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_key = '0, req0_data = '0, req1_key = '0, req1_data = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [127:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;
  logic         core_init;
  logic [127:0] core_key, core_plaintext, core_ciphertext;
  logic         core_ready;
  logic         busy, grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_req_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_key        (req0_key),
    .req0_data       (req0_data),
    .rsp0_valid      (rsp0_valid),
    .rsp0_ready      (rsp0_ready),
    .rsp0_data       (rsp0_data),
    .rsp0_err        (rsp0_err),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_key        (req1_key),
    .req1_data       (req1_data),
    .rsp1_valid      (rsp1_valid),
    .rsp1_ready      (rsp1_ready),
    .rsp1_data       (rsp1_data),
    .rsp1_err        (rsp1_err),
    .core_init       (core_init),
    .core_key        (core_key),
    .core_plaintext  (core_plaintext),
    .core_ciphertext (core_ciphertext),
    .core_ready      (core_ready),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Known FIPS-197 vectors give real ciphertext; anything else gets a keyed scramble.
  function automatic logic [127:0] coreCipher(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return {p[95:0], p[127:96]} ^ k ^ 128'ha5a5_0f0f_5a5a_f0f0_1234_5678_9abc_def0;
  endfunction

  logic         core_active;
  int           core_lat;
  logic [127:0] core_k, core_p;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_ready      <= 1'b1;
      core_ciphertext <= '0;
      core_active     <= 1'b0;
      core_lat        <= 0;
      core_k          <= '0;
      core_p          <= '0;
    end else if (core_init) begin
      core_ready  <= 1'b0;
      core_active <= 1'b1;
      core_lat    <= $urandom_range(2, 6);
      core_k      <= core_key;
      core_p      <= core_plaintext;
    end else if (core_active) begin
      if (core_lat == 0) begin
        core_ready      <= 1'b1;
        core_ciphertext <= coreCipher(core_k, core_p);
        core_active     <= 1'b0;
      end else begin
        core_lat <= core_lat - 1;
      end
    end
  end

  // Reference model: state below describes what must be visible after the next clock edge.
  int           cyc = 0;
  int           m_init = -1;
  int           m_free = 0;
  logic         m_inflight = 1'b0, m_last = 1'b1, m_gid = 1'b0, m_g = 1'b0;
  logic [1:0]   m_rv = '0;
  logic [127:0] m_data [2];
  logic [127:0] m_key = '0, m_pt = '0, m_ct = '0;
  int           acc_cnt [2];
  int           init_cnt = 0;
  logic [1:0]   elig, exp_ready;
  logic         win;
  logic [1:0]   rsp_valid_v, rsp_ready_in, rsp_err_v;
  logic [127:0] rsp_data_v [2];

  assign rsp_valid_v   = {rsp1_valid, rsp0_valid};
  assign rsp_ready_in  = {rsp1_ready, rsp0_ready};
  assign rsp_err_v     = {rsp1_err, rsp0_err};
  assign rsp_data_v[0] = rsp0_data;
  assign rsp_data_v[1] = rsp1_data;

  initial begin
    m_data[0]  = '0;
    m_data[1]  = '0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      m_inflight = 1'b0; m_last = 1'b1; m_gid = 1'b0; m_rv = '0;
      m_init = -1; m_free = 0; m_data[0] = '0; m_data[1] = '0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_rsp_valid", rsp_valid_v, 0);
      checkOutput("rst_rsp0_data", rsp0_data, 0);
      checkOutput("rst_rsp1_data", rsp1_data, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_core_init", core_init, 0);
    end else begin
      if (core_init) init_cnt++;
      checkOutput("busy", busy, m_inflight || cyc < m_free);
      checkOutput("core_init", core_init, cyc == m_init);
      checkOutput("grant_id", grant_id, m_gid);
      for (int n = 0; n < 2; n++) begin
        checkOutput($sformatf("rsp%0d_valid", n), rsp_valid_v[n], m_rv[n]);
        checkOutput($sformatf("rsp%0d_data", n), rsp_data_v[n], m_data[n]);
        checkOutput($sformatf("rsp%0d_err", n), rsp_err_v[n], 0);
      end
      if (m_inflight && cyc >= m_init) begin
        checkOutput("core_key", core_key, m_key);
        checkOutput("core_plaintext", core_plaintext, m_pt);
      end
      exp_ready = '0;
      win = 1'b0;
      if (!m_inflight && cyc >= m_free) begin
        elig = {req1_valid & ~m_rv[1], req0_valid & ~m_rv[0]};
        if (elig == 2'b11) win = ~m_last;
        else win = elig[1];
        if (elig != 2'b00) exp_ready[win] = 1'b1;
      end
      checkOutput("req_ready", {req1_ready, req0_ready}, exp_ready);
      for (int n = 0; n < 2; n++) begin
        if (m_rv[n] && rsp_ready_in[n]) m_rv[n] = 1'b0;
      end
      if (m_inflight && cyc > m_init && core_ready) begin
        m_rv[m_g]   = 1'b1;
        m_data[m_g] = m_ct;
        m_inflight  = 1'b0;
        m_free      = cyc + 2;
      end
      if (exp_ready != 2'b00) begin
        m_inflight = 1'b1;
        m_init     = cyc + 1;
        m_last     = win;
        m_gid      = win;
        m_g        = win;
        m_key      = win ? req1_key : req0_key;
        m_pt       = win ? req1_data : req0_data;
        m_ct       = coreCipher(m_key, m_pt);
        acc_cnt[win]++;
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [127:0] k0, input logic [127:0] p0,
                               input logic [127:0] k1, input logic [127:0] p1,
                               input logic r0, input logic r1);
    @(posedge clk);
    #1;
    req0_valid = v0; req1_valid = v1;
    req0_key = k0; req0_data = p0; req1_key = k1; req1_data = p1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic waitCond(input int which, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = req0_ready;
        1: hit = req1_ready;
        2: hit = rsp0_valid;
        3: hit = rsp1_valid;
        4: hit = core_init;
        5: hit = req0_ready | req1_ready;
        6: hit = !busy;
        default: hit = 1'b1;
      endcase
    end
    checkOutput(tag, hit, 1);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int a0, a1, b;
    logic v0, v1, r0, r1;
    logic [127:0] k0, p0, k1, p1;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single request from requester 0");
    b = init_cnt;
    applyStimulus(1, 0, K1, P1, '0, '0, 1, 1);
    waitCond(0, "t1_accept");
    applyStimulus(0, 0, K1, P1, '0, '0, 1, 1);
    waitCond(2, "t1_rsp0_wait");
    checkOutput("t1_rsp0_data", rsp0_data, C1);
    checkOutput("t1_rsp0_err", rsp0_err, 0);
    repeat (6) @(posedge clk);
    checkOutput("t1_init_pulses", init_cnt - b, 1);

    $display("[TB] simultaneous requests after reset");
    pulseReset();
    applyStimulus(1, 1, K1, P1, K2, P2, 1, 1);
    waitCond(5, "t2_first_accept");
    checkOutput("t2_first_is_req0", {req1_ready, req0_ready}, 2'b01);
    applyStimulus(0, 1, K1, P1, K2, P2, 1, 1);
    waitCond(1, "t2_req1_accept");
    applyStimulus(0, 0, K1, P1, K2, P2, 1, 1);
    waitCond(3, "t2_rsp1_wait");
    checkOutput("t2_rsp1_data", rsp1_data, C2);

    $display("[TB] fairness with both requesters saturated");
    waitCond(6, "t3_idle");
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    applyStimulus(1, 1, rand128(), rand128(), rand128(), rand128(), 1, 1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if ((acc_cnt[0] - a0) + (acc_cnt[1] - a1) >= 8) break;
    end
    applyStimulus(0, 0, '0, '0, '0, '0, 1, 1);
    checkOutput("t3_req0_grants", acc_cnt[0] - a0, 4);
    checkOutput("t3_req1_grants", acc_cnt[1] - a1, 4);

    $display("[TB] requester 0 blocked by an unconsumed response");
    waitCond(6, "t4_idle");
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    applyStimulus(1, 1, K1, P1, rand128(), rand128(), 0, 1);
    repeat (80) @(negedge clk);
    #1;
    checkOutput("t4_req0_grants", acc_cnt[0] - a0, 1);
    checkOutput("t4_req1_served", (acc_cnt[1] - a1) >= 2, 1);
    checkOutput("t4_rsp0_valid", rsp0_valid, 1);
    checkOutput("t4_rsp0_data", rsp0_data, C1);
    applyStimulus(0, 0, '0, '0, '0, '0, 1, 1);

    $display("[TB] reset during a core operation");
    waitCond(6, "t5_idle");
    applyStimulus(1, 0, K2, P2, '0, '0, 1, 1);
    waitCond(4, "t5_init");
    applyStimulus(0, 0, K2, P2, '0, '0, 1, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(1, 0, K1, P1, '0, '0, 1, 1);
    waitCond(0, "t5_accept");
    applyStimulus(0, 0, K1, P1, '0, '0, 1, 1);
    waitCond(2, "t5_rsp0_wait");
    checkOutput("t5_rsp0_data", rsp0_data, C1);

    $display("[TB] randomized traffic");
    v0 = 0; v1 = 0; k0 = '0; p0 = '0; k1 = '0; p1 = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1'b1;
        if ($urandom_range(0, 3) == 0) begin k0 = K1; p0 = P1; end
        else begin k0 = rand128(); p0 = rand128(); end
      end else if (v0 && $urandom_range(0, 7) == 0) begin
        v0 = 1'b0;
      end
      if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1'b1;
        if ($urandom_range(0, 3) == 0) begin k1 = K2; p1 = P2; end
        else begin k1 = rand128(); p1 = rand128(); end
      end else if (v1 && $urandom_range(0, 7) == 0) begin
        v1 = 1'b0;
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      applyStimulus(v0, v1, k0, p0, k1, p1, r0, r1);
    end
    applyStimulus(0, 0, '0, '0, '0, '0, 1, 1);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
